// File: rtl/rs_age_station.sv
// Reservation station: entries wait on ROB tags, are woken by NWAKE broadcast ports, and the oldest ready entry issues.
// Latency: 2 edges from dispatch/wake to issue_valid; issue register holds stable while issue_ready is low.
module rs_age_station #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 5,
    parameter int XLEN  = 32,
    parameter int NWAKE = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_type,
    input  logic [3:0]               in_op,
    input  logic [ROB_W-1:0]         in_rob_id,
    input  logic [XLEN-1:0]          in_v1,
    input  logic [XLEN-1:0]          in_v2,
    input  logic [XLEN-1:0]          in_imm,
    input  logic                     in_q1_valid,
    input  logic                     in_q2_valid,
    input  logic [ROB_W-1:0]         in_q1,
    input  logic [ROB_W-1:0]         in_q2,
    input  logic [NWAKE-1:0]         wake_valid,
    input  logic [NWAKE*ROB_W-1:0]   wake_rob_id,
    input  logic [NWAKE*XLEN-1:0]    wake_value,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [ROB_W-1:0]         issue_rob_id,
    output logic [6:0]               issue_type,
    output logic [3:0]               issue_op,
    output logic [XLEN-1:0]          issue_v1,
    output logic [XLEN-1:0]          issue_v2,
    output logic [CNT_W-1:0]         count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [6:0]       typ;
        logic [3:0]       op;
        logic [ROB_W-1:0] rob_id;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [XLEN-1:0]  imm;
        logic [ROB_W-1:0] q1;
        logic [ROB_W-1:0] q2;
    } ent_t;

    ent_t             ent [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] q1_vld;
    logic [DEPTH-1:0] q2_vld;
    logic [DEPTH-1:0] older [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] sel_vec;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             blk;
    logic             any_ready;
    logic             run;
    logic             alloc;
    logic             can_issue;
    logic             do_sel;
    logic [XLEN:0]    w1 [DEPTH];
    logic [XLEN:0]    w2 [DEPTH];
    logic [XLEN:0]    in_w1;
    logic [XLEN:0]    in_w2;

    // Returns {hit, value}; scanning downward lets the lowest matching port win.
    function automatic logic [XLEN:0] wake_match(
        input logic [ROB_W-1:0]       tag,
        input logic [NWAKE-1:0]       wv,
        input logic [NWAKE*ROB_W-1:0] wt,
        input logic [NWAKE*XLEN-1:0]  wd
    );
        logic [XLEN:0] r;
        r = '0;
        for (int p = NWAKE - 1; p >= 0; p--) begin
            if (wv[p] && (wt[p*ROB_W +: ROB_W] == tag))
                r = {1'b1, wd[p*XLEN +: XLEN]};
        end
        return r;
    endfunction

    always_comb begin
        ready     = busy & ~q1_vld & ~q2_vld;
        any_ready = |ready;
        sel_vec   = '0;
        sel_idx   = '0;
        free_idx  = '0;
        blk       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blk = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older[j][i])
                    blk = 1'b1;
            end
            sel_vec[i] = ready[i] && !blk;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel_vec[i])
                sel_idx = IDX_W'(i);
            if (!busy[i])
                free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w1[i] = wake_match(ent[i].q1, wake_valid, wake_rob_id, wake_value);
            w2[i] = wake_match(ent[i].q2, wake_valid, wake_rob_id, wake_value);
        end
        in_w1 = wake_match(in_q1, wake_valid, wake_rob_id, wake_value);
        in_w2 = wake_match(in_q2, wake_valid, wake_rob_id, wake_value);
    end

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign run       = rdy_in && !flush_in;
    assign alloc     = run && in_valid && in_ready;
    assign can_issue = !issue_valid || issue_ready;
    assign do_sel    = run && can_issue && any_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy         <= '0;
            q1_vld       <= '0;
            q2_vld       <= '0;
            count        <= '0;
            issue_valid  <= 1'b0;
            issue_rob_id <= '0;
            issue_type   <= '0;
            issue_op     <= '0;
            issue_v1     <= '0;
            issue_v2     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i]   <= '0;
                older[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                busy        <= '0;
                q1_vld      <= '0;
                q2_vld      <= '0;
                count       <= '0;
                issue_valid <= 1'b0;
                for (int i = 0; i < DEPTH; i++)
                    older[i] <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i] && q1_vld[i] && w1[i][XLEN]) begin
                        ent[i].v1 <= w1[i][XLEN-1:0];
                        q1_vld[i] <= 1'b0;
                    end
                    if (busy[i] && q2_vld[i] && w2[i][XLEN]) begin
                        ent[i].v2 <= w2[i][XLEN-1:0];
                        q2_vld[i] <= 1'b0;
                    end
                end

                if (do_sel)
                    busy[sel_idx] <= 1'b0;

                // The free slot is never busy, so it cannot collide with the selected or woken entries.
                if (alloc) begin
                    busy[free_idx]          <= 1'b1;
                    ent[free_idx].typ       <= in_type;
                    ent[free_idx].op        <= in_op;
                    ent[free_idx].rob_id    <= in_rob_id;
                    ent[free_idx].imm       <= in_imm;
                    ent[free_idx].q1        <= in_q1;
                    ent[free_idx].q2        <= in_q2;
                    ent[free_idx].v1        <= (in_q1_valid && in_w1[XLEN]) ? in_w1[XLEN-1:0] : in_v1;
                    ent[free_idx].v2        <= (in_q2_valid && in_w2[XLEN]) ? in_w2[XLEN-1:0] : in_v2;
                    q1_vld[free_idx]        <= in_q1_valid && !in_w1[XLEN];
                    q2_vld[free_idx]        <= in_q2_valid && !in_w2[XLEN];
                    for (int j = 0; j < DEPTH; j++)
                        older[j][free_idx] <= busy[j];
                    older[free_idx]         <= '0;
                end

                case ({alloc, do_sel})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase

                if (can_issue) begin
                    issue_valid <= any_ready;
                    if (any_ready) begin
                        issue_rob_id <= ent[sel_idx].rob_id;
                        issue_type   <= ent[sel_idx].typ;
                        issue_op     <= ent[sel_idx].op;
                        issue_v1     <= ent[sel_idx].v1;
                        issue_v2     <= ((ent[sel_idx].typ == 7'b0110011) || (ent[sel_idx].typ == 7'b1100011))
                                        ? ent[sel_idx].v2 : ent[sel_idx].imm;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_age_station.sv
// Directed bench for rs_age_station: dispatch, wakeup, bypass, age ordering, back-pressure, flush, reset, freeze.
module tb_rs_age_station;

    localparam int DEPTH = 8;
    localparam int ROB_W = 5;
    localparam int XLEN  = 32;
    localparam int NWAKE = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   clk_in, rst_in, rdy_in, flush_in;
    logic                   in_valid, in_ready;
    logic [6:0]             in_type;
    logic [3:0]             in_op;
    logic [ROB_W-1:0]       in_rob_id, in_q1, in_q2;
    logic [XLEN-1:0]        in_v1, in_v2, in_imm;
    logic                   in_q1_valid, in_q2_valid;
    logic [NWAKE-1:0]       wake_valid;
    logic [NWAKE*ROB_W-1:0] wake_rob_id;
    logic [NWAKE*XLEN-1:0]  wake_value;
    logic                   issue_valid, issue_ready;
    logic [ROB_W-1:0]       issue_rob_id;
    logic [6:0]             issue_type;
    logic [3:0]             issue_op;
    logic [XLEN-1:0]        issue_v1, issue_v2;
    logic [CNT_W-1:0]       count;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] T_IMM = 7'b0010011;
    localparam logic [6:0] T_REG = 7'b0110011;

    rs_age_station #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN), .NWAKE(NWAKE), .CNT_W(CNT_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_op(in_op),
        .in_rob_id(in_rob_id), .in_v1(in_v1), .in_v2(in_v2), .in_imm(in_imm),
        .in_q1_valid(in_q1_valid), .in_q2_valid(in_q2_valid), .in_q1(in_q1), .in_q2(in_q2),
        .wake_valid(wake_valid), .wake_rob_id(wake_rob_id), .wake_value(wake_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob_id(issue_rob_id),
        .issue_type(issue_type), .issue_op(issue_op), .issue_v1(issue_v1), .issue_v2(issue_v2),
        .count(count)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_q1_valid = 1'b0;
        in_q2_valid = 1'b0;
        wake_valid  = '0;
    endtask

    task automatic drive(input logic [ROB_W-1:0] rob, input logic [6:0] typ, input logic [XLEN-1:0] v1,
                         input logic [XLEN-1:0] v2, input logic [XLEN-1:0] imm,
                         input logic q1v, input logic [ROB_W-1:0] q1, input logic q2v, input logic [ROB_W-1:0] q2);
        in_valid = 1'b1; in_rob_id = rob; in_type = typ; in_op = 4'd0;
        in_v1 = v1; in_v2 = v2; in_imm = imm;
        in_q1_valid = q1v; in_q1 = q1; in_q2_valid = q2v; in_q2 = q2;
    endtask

    task automatic set_wake(input int p, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] val);
        wake_valid[p] = 1'b1;
        wake_rob_id[p*ROB_W +: ROB_W] = tag;
        wake_value[p*XLEN +: XLEN] = val;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; issue_ready = 1'b1;
        in_type = '0; in_op = '0; in_rob_id = '0; in_v1 = '0; in_v2 = '0; in_imm = '0;
        in_q1 = '0; in_q2 = '0; wake_rob_id = '0; wake_value = '0;
        idle();
        #3;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tick(); tick();
        rst_in = 1'b0;
        checks++; if (issue_rob_id !== 5'd0 || issue_type !== 7'd0 || issue_op !== 4'd0)
            begin errors++; $display("FAIL reset_issue_fields got rob=%0d type=%0d op=%0d want 0", issue_rob_id, issue_type, issue_op); end
        checks++; if (issue_v1 !== 32'd0 || issue_v2 !== 32'd0)
            begin errors++; $display("FAIL reset_issue_vals got v1=%h v2=%h want 0", issue_v1, issue_v2); end
        tick();
    endtask

    task automatic test_basic();
        drive(5'd3, T_IMM, 32'd5, 32'd99, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        checks++; if (count !== 4'd1 || issue_valid !== 1'b0)
            begin errors++; $display("FAIL basic_after_dispatch got count=%0d valid=%b want 1/0", count, issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd3)
            begin errors++; $display("FAIL basic_issue got valid=%b rob=%0d want 1/3", issue_valid, issue_rob_id); end
        checks++; if (issue_v1 !== 32'd5 || issue_v2 !== 32'd7 || issue_type !== T_IMM)
            begin errors++; $display("FAIL basic_operands got v1=%0d v2=%0d type=%b want 5/7/0010011", issue_v1, issue_v2, issue_type); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_count got %0d want 0", count); end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got %b want 0", issue_valid); end
    endtask

    task automatic test_tag_zero();
        drive(5'd0, T_REG, 32'd1, 32'h22, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        tick(); tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd1)
            begin errors++; $display("FAIL tag0_waits got valid=%b count=%0d want 0/1", issue_valid, count); end
        set_wake(2, 5'd0, 32'hDEAD);
        tick();
        idle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL tag0_latency got %b want 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd0 || issue_v1 !== 32'hDEAD || issue_v2 !== 32'h22)
            begin errors++; $display("FAIL tag0_issue got valid=%b rob=%0d v1=%h v2=%h want 1/0/dead/22", issue_valid, issue_rob_id, issue_v1, issue_v2); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive(5'(10 + i), T_IMM, 32'd0, 32'd0, 32'(i), 1'b1, 5'd9, 1'b0, 5'd0);
            tick();
        end
        checks++; if (count !== 4'd8 || in_ready !== 1'b0)
            begin errors++; $display("FAIL full_state got count=%0d in_ready=%b want 8/0", count, in_ready); end
        drive(5'd30, T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        tick();
        checks++; if (count !== 4'd8 || issue_valid !== 1'b0)
            begin errors++; $display("FAIL full_drop got count=%0d valid=%b want 8/0", count, issue_valid); end
        set_wake(0, 5'd9, 32'd1);
        tick();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'(10 + i) || issue_v1 !== 32'd1 || issue_v2 !== 32'(i))
                begin errors++; $display("FAIL full_order[%0d] got valid=%b rob=%0d v1=%0d v2=%0d want 1/%0d/1/%0d",
                                         i, issue_valid, issue_rob_id, issue_v1, issue_v2, 10 + i, i); end
            checks++; if (count !== 4'(7 - i) || in_ready !== 1'b1)
                begin errors++; $display("FAIL full_count[%0d] got count=%0d in_ready=%b want %0d/1", i, count, in_ready, 7 - i); end
        end
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0)
            begin errors++; $display("FAIL full_end got valid=%b count=%0d want 0/0", issue_valid, count); end
    endtask

    task automatic test_backpressure();
        issue_ready = 1'b0;
        drive(5'd4, T_IMM, 32'd0, 32'd0, 32'h44, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(5'd5, T_IMM, 32'd0, 32'd0, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd4 || issue_v2 !== 32'h44 || count !== 4'd1)
                begin errors++; $display("FAIL stall_hold[%0d] got valid=%b rob=%0d v2=%h count=%0d want 1/4/44/1",
                                         i, issue_valid, issue_rob_id, issue_v2, count); end
        end
        issue_ready = 1'b1;
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd5 || issue_v2 !== 32'h55 || count !== 4'd0)
            begin errors++; $display("FAIL stall_release got valid=%b rob=%0d v2=%h count=%0d want 1/5/55/0",
                                     issue_valid, issue_rob_id, issue_v2, count); end
        tick();
    endtask

    task automatic test_bypass();
        drive(5'd6, T_REG, 32'd0, 32'd0, 32'd0, 1'b1, 5'd12, 1'b1, 5'd13);
        set_wake(0, 5'd12, 32'h111);
        set_wake(1, 5'd12, 32'h999);
        set_wake(2, 5'd13, 32'h222);
        tick();
        idle();
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd6 || issue_v1 !== 32'h111 || issue_v2 !== 32'h222)
            begin errors++; $display("FAIL bypass got valid=%b rob=%0d v1=%h v2=%h want 1/6/111/222", issue_valid, issue_rob_id, issue_v1, issue_v2); end
        drive(5'd7, T_IMM, 32'd0, 32'd0, 32'h8, 1'b1, 5'd14, 1'b0, 5'd0);
        tick();
        idle();
        set_wake(1, 5'd14, 32'hAAA);
        set_wake(2, 5'd14, 32'hBBB);
        tick();
        idle();
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd7 || issue_v1 !== 32'hAAA || issue_v2 !== 32'h8)
            begin errors++; $display("FAIL wake_priority got valid=%b rob=%0d v1=%h v2=%h want 1/7/aaa/8", issue_valid, issue_rob_id, issue_v1, issue_v2); end
        tick();
    endtask

    task automatic test_age();
        issue_ready = 1'b0;
        drive(5'd50, T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(5'd51, T_IMM, 32'd0, 32'd0, 32'd0, 1'b1, 5'd16, 1'b0, 5'd0);
        tick();
        drive(5'd52, T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd50)
            begin errors++; $display("FAIL age_first got valid=%b rob=%0d want 1/50", issue_valid, issue_rob_id); end
        drive(5'd53, T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_wake(0, 5'd16, 32'd3);
        tick();
        idle();
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'(51 + i))
                begin errors++; $display("FAIL age_order[%0d] got valid=%b rob=%0d want 1/%0d", i, issue_valid, issue_rob_id, 51 + i); end
        end
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0)
            begin errors++; $display("FAIL age_end got valid=%b count=%0d want 0/0", issue_valid, count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(5'(40 + i), T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            else idle();
            tick();
            if (i >= 1 && i <= 4) begin
                checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'(39 + i))
                    begin errors++; $display("FAIL b2b[%0d] got valid=%b rob=%0d want 1/%0d", i, issue_valid, issue_rob_id, 39 + i); end
            end
        end
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0)
            begin errors++; $display("FAIL b2b_end got valid=%b count=%0d want 0/0", issue_valid, count); end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(5'(20 + i), T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
        end
        checks++; if (count !== 4'd4 || issue_valid !== 1'b1 || issue_rob_id !== 5'd20)
            begin errors++; $display("FAIL flush_pre got count=%0d valid=%b rob=%0d want 4/1/20", count, issue_valid, issue_rob_id); end
        flush_in = 1'b1;
        drive(5'd25, T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        flush_in = 1'b0;
        idle();
        checks++; if (count !== 4'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_clear got count=%0d valid=%b in_ready=%b want 0/0/1", count, issue_valid, in_ready); end
        issue_ready = 1'b1;
        tick(); tick();
        checks++; if (count !== 4'd0 || issue_valid !== 1'b0)
            begin errors++; $display("FAIL flush_after got count=%0d valid=%b want 0/0", count, issue_valid); end
    endtask

    task automatic test_async_reset();
        issue_ready = 1'b0;
        drive(5'd8, T_IMM, 32'd9, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(5'd9, T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        checks++; if (issue_valid !== 1'b1 || count !== 4'd1)
            begin errors++; $display("FAIL arst_pre got valid=%b count=%0d want 1/1", issue_valid, count); end
        #2 rst_in = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1 || issue_rob_id !== 5'd0 || issue_v1 !== 32'd0)
            begin errors++; $display("FAIL arst_clear got valid=%b count=%0d in_ready=%b rob=%0d v1=%h want 0/0/1/0/0",
                                     issue_valid, count, in_ready, issue_rob_id, issue_v1); end
        #1 rst_in = 1'b0;
        issue_ready = 1'b1;
        tick(); tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0)
            begin errors++; $display("FAIL arst_after got valid=%b count=%0d want 0/0", issue_valid, count); end
    endtask

    task automatic test_rdy_low();
        issue_ready = 1'b0;
        drive(5'd1, T_IMM, 32'd0, 32'd0, 32'h10, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(5'd2, T_IMM, 32'd0, 32'd0, 32'd0, 1'b1, 5'd15, 1'b0, 5'd0);
        tick();
        rdy_in = 1'b0;
        issue_ready = 1'b1;
        drive(5'd3, T_IMM, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_wake(0, 5'd15, 32'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd1 || issue_v2 !== 32'h10 || count !== 4'd1)
                begin errors++; $display("FAIL freeze[%0d] got valid=%b rob=%0d v2=%h count=%0d want 1/1/10/1",
                                         i, issue_valid, issue_rob_id, issue_v2, count); end
        end
        rdy_in = 1'b1;
        idle();
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd1)
            begin errors++; $display("FAIL freeze_wake_lost got valid=%b count=%0d want 0/1", issue_valid, count); end
        set_wake(0, 5'd15, 32'h77);
        tick();
        idle();
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 5'd2 || issue_v1 !== 32'h77 || count !== 4'd0)
            begin errors++; $display("FAIL freeze_rewake got valid=%b rob=%0d v1=%h count=%0d want 1/2/77/0",
                                     issue_valid, issue_rob_id, issue_v1, count); end
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0)
            begin errors++; $display("FAIL freeze_end got valid=%b count=%0d want 0/0", issue_valid, count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tag_zero();
        test_full();
        test_backpressure();
        test_bypass();
        test_age();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_rdy_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_age_station.md
# rs_age_station

Parametrised reservation station for the out-of-order core. It sits between instruction dispatch and the ALU. Entries wait for operands by ROB tag and are woken by N broadcast ports. The oldest ready entry issues through a valid/ready output register that tolerates ALU back-pressure. Dependency tags carry explicit valid bits, so ROB id 0 is an ordinary tag.

## Interface
- DEPTH, 8: number of entries (2..16).
- ROB_W, 5: ROB tag width.
- XLEN, 32: operand width.
- NWAKE, 3: number of wakeup/broadcast ports.
- CNT_W, $clog2(DEPTH+1): occupancy width.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush_in  in  1  synchronous clear of all entries and the issue register (mispredict).
- in_valid  in  1  dispatch request.
- in_ready  out  1  entry free; equals (count < DEPTH).
- in_type  in  7  opcode class.
- in_op  in  4  ALU op.
- in_rob_id  in  ROB_W  destination tag.
- in_v1, in_v2, in_imm  in  XLEN  operand values and immediate.
- in_q1_valid, in_q2_valid  in  1  operand still pending.
- in_q1, in_q2  in  ROB_W  pending producer tags.
- wake_valid  in  NWAKE  per-port broadcast valid.
- wake_rob_id  in  NWAKE*ROB_W  packed tags; port p at [p*ROB_W +: ROB_W].
- wake_value  in  NWAKE*XLEN  packed values.
- issue_valid  out  1  ALU request.
- issue_ready  in  1  ALU accepts.
- issue_rob_id / issue_type / issue_op  out  ROB_W / 7 / 4  issued fields.
- issue_v1, issue_v2  out  XLEN  operands. issue_v2 = v2 when type is 7'b0110011 or 7'b1100011, otherwise imm.
- count  out  CNT_W  occupied entries.

## Operation
- Per-entry state: busy, type, op, rob_id, v1, v2, imm, q1_valid/q1, q2_valid/q2, plus a DEPTH×DEPTH age matrix (older[j][i] = 1 means j was allocated before i).
- Allocation occurs when in_valid && in_ready && rdy_in && !flush_in. The target is the lowest-index free slot k.
  - Set older[j][k] = busy[j] for all j, and older[k][*] = 0.
  - Each operand captures the matching wake port value in the same cycle (bypass) and clears its q_valid.
- Wakeup: for every busy entry and each operand with q_valid, a match on any valid wake port loads the value and clears q_valid.
  - If several ports match, the lowest port index wins.
  - Allocation bypass and wakeup use the same priority.
- ready[i] = busy[i] && !q1_valid[i] && !q2_valid[i], evaluated from registered state only.
- Selection: the oldest ready entry, i.e. ready[i] with no ready j where older[j][i] = 1. At most one entry qualifies.
- Issue register loads when (!issue_valid || issue_ready) and a ready entry exists.
  - The selected slot's busy clears on that edge.
  - If no ready entry exists and issue_ready is high, issue_valid drops.
- While issue_valid && !issue_ready, the issue outputs hold stable and no entry is selected.
- count = count + alloc - select on the same edge. Both together leave it unchanged.
- Priority: rst_in > flush_in > normal operation. Flush clears busy, all q_valid, the age matrix, count and issue_valid. Flush ignores in_valid in that cycle.
- rdy_in low: no allocation, wakeup, selection or handshake. Wake inputs seen during that time are lost, and the producer must re-broadcast.

## Timing
- Reset (async): issue_valid = 0; issue_rob_id, issue_type, issue_op, issue_v1, issue_v2 = 0; count = 0; in_ready = 1; all busy and q_valid = 0.
- Entry dispatched with both operands ready at edge t: selectable during cycle t..t+1, issue_valid high after edge t+1. Latency is 2 edges.
- Wake at edge t (or dispatch bypass at edge t): same 2-edge latency to issue_valid.
- One issue per cycle maximum. With issue_ready tied high, throughput is 1 per cycle.
- A slot freed at edge t is visible to in_ready after edge t. There is no same-cycle reuse of a slot being freed.
- Full: count = DEPTH gives in_ready = 0. in_valid is then ignored and no state changes.

## Test plan
- Reset, then dispatch rob 3 ADD (v1 = 5, imm = 7, type 0010011) with no deps → issue_valid two edges later, v1 = 5, v2 = 7, count back to 0.
- Dispatch rob 0 with q1 = 0 pending, then wake port 2 with tag 0 and value 0xDEAD → issues with v1 = 0xDEAD. Tag 0 is not treated as ready before the wake.
- Fill DEPTH entries, all waiting on tag 9 → in_ready = 0 and extra dispatches are dropped. Broadcast tag 9 with 1 → the entries issue in allocation order, one per cycle, and in_ready returns.
- Hold issue_ready = 0 for 5 cycles with 2 ready entries → outputs stay stable. After release, the second entry follows on the next cycle.
- Dispatch in the same cycle as a matching wake on port 0 → the value is bypassed into the entry. Ports 0 and 1 matching simultaneously → port 0's value is used.
- Mid-operation tests:
  - Flush with 4 busy entries and issue_valid = 1 → count = 0 and issue_valid = 0 next cycle.
  - rst_in pulse between edges → outputs clear immediately.
  - rdy_in low for 3 cycles → state unchanged.
